imm_ext_pipe: RTL and testbench



---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_ext_comb.sv | 41 ++++
 rtl/imm_ext_pipe.sv | 103 ++++++++++
 tb/tb_imm_ext_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extraction path: format codes,
// XLEN legality and the opcode-to-format mapping used by the decoder.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_U     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_RSV   = 3'b111;

  function automatic bit xlen_legal(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Shift-immediates and CSR-immediate forms need funct3 to pick their format.
  function automatic logic [2:0] opcode_to_type(logic [6:0] opcode, logic [2:0] funct3);
    logic [2:0] t;
    t = IMM_RSV;
    case (opcode)
      7'b0000011, 7'b1100111: t = IMM_I;
      7'b0010011, 7'b0011011: t = (funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      7'b0100011:             t = IMM_S;
      7'b0110111, 7'b0010111: t = IMM_U;
      7'b1100011:             t = IMM_B;
      7'b1101111:             t = IMM_J;
      7'b1110011:             t = funct3[2] ? IMM_ZIMM : IMM_I;
      default:                t = IMM_RSV;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational RISC-V immediate extractor, sign/zero-extended to XLEN.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      type_SE,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [31:0] u_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;

  assign i_imm = inst[31:20];
  assign s_imm = {inst[31:25], inst[11:7]};
  assign u_imm = {inst[31:12], 12'b0};
  assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Signed sources sign-extend through the size cast.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (type_SE)
      IMM_I:     imm = XLEN'(i_imm);
      IMM_S:     imm = XLEN'(s_imm);
      IMM_U:     imm = XLEN'(u_imm);
      IMM_B:     imm = XLEN'(b_imm);
      IMM_J:     imm = XLEN'(j_imm);
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      IMM_ZIMM:  imm = XLEN'(inst[19:15]);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Handshaked immediate extraction stage: extractor feeding an output
// register backed by one skid entry, so in_ready comes straight from a flop.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int GEN_TARGET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      type_SE,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inmExt,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] imm_p0;
  logic [XLEN-1:0] tgt_p0;
  logic            ill_p0;
  logic            accept_p0;
  logic            load_out_p0;

  logic            vld_p1;
  logic [XLEN-1:0] imm_p1;
  logic [XLEN-1:0] tgt_p1;
  logic            ill_p1;
  logic            skid_vld_p1;
  logic [XLEN-1:0] skid_imm_p1;
  logic [XLEN-1:0] skid_tgt_p1;
  logic            skid_ill_p1;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .type_SE (type_SE),
    .inst    (inst),
    .imm     (imm_p0),
    .illegal (ill_p0)
  );

  if (GEN_TARGET != 0) begin : g_target
    assign tgt_p0 = pc + imm_p0;
  end else begin : g_no_target
    assign tgt_p0 = '0;
  end

  assign accept_p0   = in_valid && !skid_vld_p1 && !flush;
  assign load_out_p0 = !vld_p1 || out_ready;

  // ---- stage p0 -> p1: output register and skid entry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      tgt_p1      <= '0;
      ill_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_tgt_p1 <= '0;
      skid_ill_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (load_out_p0) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        imm_p1      <= skid_imm_p1;
        tgt_p1      <= skid_tgt_p1;
        ill_p1      <= skid_ill_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept_p0) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_p0;
        tgt_p1 <= tgt_p0;
        ill_p1 <= ill_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept_p0) begin
      // Output is stalled: park the new beat behind it.
      skid_vld_p1 <= 1'b1;
      skid_imm_p1 <= imm_p0;
      skid_tgt_p1 <= tgt_p0;
      skid_ill_p1 <= ill_p0;
    end
  end

  assign in_ready  = !skid_vld_p1;
  assign out_valid = vld_p1;
  assign inmExt    = imm_p1;
  assign target    = tgt_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances driven in lockstep
// against a queue-based reference of the held beats.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [2:0]  type_SE;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] inmExt32, target32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] inmExt64, target64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .GEN_TARGET(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .type_SE(type_SE), .pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .inmExt(inmExt32), .target(target32), .illegal(illegal32)
  );

  imm_ext_pipe #(.XLEN(64), .GEN_TARGET(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .type_SE(type_SE), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .inmExt(inmExt64), .target(target64), .illegal(illegal64)
  );

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        ill;
  } beat_t;

  beat_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] i, input logic [2:0] t);
    longint v;
    v = 0;
    case (t)
      3'd0: v = longint'($signed(i) >>> 20);
      3'd1: v = longint'($signed(i) >>> 25) * 32 + longint'(i[11:7]);
      3'd2: v = longint'($signed(i & 32'hFFFF_F000));
      3'd3: begin
        if (i[31]) v = -4096;
        v = v + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      3'd4: begin
        if (i[31]) v = -1048576;
        v = v + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      3'd5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] ref_tgt(input int xlen, input logic [63:0] p, input logic [63:0] imm);
    logic [63:0] s;
    s = p + imm;
    return (xlen == 32) ? {32'b0, s[31:0]} : s;
  endfunction

  task automatic check_state();
    check_eq("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    check_eq("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    check_eq("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    check_eq("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check_eq("inmExt32", 64'(inmExt32), q[0].imm32);
      check_eq("target32", 64'(target32), q[0].tgt32);
      check_eq("illegal32", 64'(illegal32), 64'(q[0].ill));
      check_eq("inmExt64", inmExt64, q[0].imm64);
      check_eq("target64", target64, q[0].tgt64);
      check_eq("illegal64", 64'(illegal64), 64'(q[0].ill));
    end
  endtask

  // One clock: update the reference with the inputs seen at the edge, then check.
  task automatic step();
    beat_t b;
    int    sz;
    @(posedge clk);
    sz = q.size();
    if (flush) begin
      q.delete();
    end else begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) begin
        b.imm32 = ref_imm(32, inst, type_SE);
        b.tgt32 = ref_tgt(32, {32'b0, pc32}, b.imm32);
        b.imm64 = ref_imm(64, inst, type_SE);
        b.tgt64 = ref_tgt(64, pc64, b.imm64);
        b.ill   = (type_SE == 3'b111);
        q.push_back(b);
      end
    end
    #1;
    check_state();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] t, input logic [63:0] p);
    in_valid = v;
    inst     = i;
    type_SE  = t;
    pc32     = p[31:0];
    pc64     = p;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid32), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready32), 64'd1);
    check_eq("rst_inmExt", inmExt64, 64'd0);
    check_eq("rst_target", 64'(target32), 64'd0);
    check_eq("rst_illegal", 64'(illegal64), 64'd0);
    rst_n = 1'b1;

    drive(1'b1, 32'hFFF00093, 3'b000, 64'h0); step();
    check_eq("tp1_imm", 64'(inmExt32), 64'hFFFF_FFFF);
    check_eq("tp1_ill", 64'(illegal32), 64'd0);
    drive(1'b1, 32'hFE20AE23, 3'b001, 64'h0); step();
    check_eq("tp2_s_imm", 64'(inmExt32), 64'hFFFF_FFFC);
    drive(1'b1, 32'hFE000CE3, 3'b011, 64'h100); step();
    check_eq("tp2_b_imm", 64'(inmExt32), 64'hFFFF_FFF8);
    check_eq("tp2_b_tgt", 64'(target32), 64'h0000_00F8);
    drive(1'b1, 32'h010000EF, 3'b100, 64'hFFFF_FFF8); step();
    check_eq("tp3_j_imm", 64'(inmExt32), 64'h10);
    check_eq("tp3_j_wrap", 64'(target32), 64'h8);
    drive(1'b1, 32'h12345678, 3'b111, 64'h40); step();
    check_eq("tp3_rsv_imm", 64'(inmExt32), 64'h0);
    check_eq("tp3_rsv_ill", 64'(illegal32), 64'h1);
    drive(1'b1, 32'h800000B7, 3'b010, 64'h0); step();
    check_eq("tp4_u64", inmExt64, 64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h03F01013, 3'b101, 64'h0); step();
    check_eq("tp4_shamt64", inmExt64, 64'h3F);
    check_eq("tp4_shamt32", 64'(inmExt32), 64'h1F);
    drive(1'b1, 32'h0007D073, 3'b110, 64'h0); step();
    check_eq("zimm", 64'(inmExt32), 64'h0F);
    drive(1'b0, 32'h0, 3'd0, 64'h0); step();

    // Backpressure: A then B stall, C offered while full must not enter.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 64'h10); step();
    drive(1'b1, 32'h7FF00093, 3'b000, 64'h20); step();
    check_eq("bp_in_ready_full", 64'(in_ready32), 64'd0);
    drive(1'b1, 32'h00100093, 3'b000, 64'h30); step(); step();
    check_eq("bp_hold_A", 64'(inmExt32), 64'hFFFF_FFFF);
    drive(1'b0, 32'h0, 3'd0, 64'h0);
    out_ready = 1'b1; step();
    check_eq("bp_B_next", 64'(inmExt32), 64'h7FF);
    step();
    check_eq("bp_empty", 64'(out_valid32), 64'd0);

    // Flush from FULL with a beat offered in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 3'b000, 64'h0); step(); step();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00700093, 3'b000, 64'h0); step();
    check_eq("flush_out_valid", 64'(out_valid32), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready64), 64'd1);
    flush = 1'b0; drive(1'b0, 32'h0, 3'd0, 64'h0); step();
    check_eq("flush_beat_absent", 64'(out_valid64), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
      step();
    end

    // Asynchronous reset while holding beats.
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 64'h0); step(); step();
    rst_n = 1'b0;
    #2;
    check_eq("arst_out_valid32", 64'(out_valid32), 64'd0);
    check_eq("arst_out_valid64", 64'(out_valid64), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready32), 64'd1);
    check_eq("arst_inmExt", 64'(inmExt32), 64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
